// File: rtl/uart_console_tx.sv
// uart_console_tx: FIFO-buffered 8N1 UART transmitter with valid/ready back-pressure on the console byte stream.
module uart_console_tx #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          CLK_undiv,
  input  logic                          RESET_n,
  input  logic [7:0]                    CONSOLE_OUT,
  input  logic                          CONSOLE_OUT_valid,
  output logic                          CONSOLE_OUT_ready,
  output logic                          TX,
  output logic                          BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_console_tx: CLK_FREQ_HZ / BAUD must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_console_tx: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ready_q, ready_d;
  logic            tx_q, tx_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic            push, pop, last;

  always_ff @(posedge CLK_undiv or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      tx_q     <= tx_d;
    end
  end

  always_ff @(posedge CLK_undiv) begin
    if (push) mem_q[wr_ptr_q] <= CONSOLE_OUT;
  end

  // A STOP bit that ends with data waiting chains straight into the next START.
  always_comb begin
    last    = timer_q == T_LAST;
    pop     = 1'b0;
    state_d = state_q;
    timer_d = last ? '0 : timer_q + TW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: if (last) begin
        state_d = DATA;
        idx_d   = '0;
      end
      DATA: if (last) begin
        if (idx_q == 3'd7) state_d = STOP;
        else idx_d = idx_q + 3'd1;
      end
      STOP: if (last) begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = START;
        end else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (pop) shift_d = mem_q[rd_ptr_q];
  end

  always_comb begin
    push     = CONSOLE_OUT_valid && ready_q;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    ready_d  = count_d < FULL;
  end

  // TX is registered from the next-state view so the line changes only on clock edges.
  always_comb begin
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[idx_d] : 1'b1;
    BUSY = state_q != IDLE;
  end

  assign TX                = tx_q;
  assign CONSOLE_OUT_ready = ready_q;
  assign FIFO_COUNT        = count_q;
endmodule
